timer_irq_ctrl: RTL and testbench

//  Programmable interval timer that produces the CPU's i_timer interrupt request.
//  - Sits upstream of the cpu top. The CPU programs it through its output-port write path (we_o, io_port, hilo_out, out_pN data).
//  - The CPU acknowledges the interrupt with its finish-interrupt pulse.
//  - Counter and status are returned to the CPU through an input port.

---
 rtl/cpu_io_pkg.sv | 30 +++
 rtl/timer_prescaler.sv | 40 ++++
 rtl/timer_irq_ctrl.sv | 133 +++++++++++++
 tb/tb_timer_irq_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_io_pkg.sv
//------------------------------------------------------------------------------
// Module  : cpu_io_pkg
// Brief   : Shared CPU output-port constants and timer state type.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_io_pkg;

    localparam logic [1:0] PORT_ID_TIMER = 2'd3;

    localparam logic [1:0] REG_RELOAD_LO = 2'b00;
    localparam logic [1:0] REG_RELOAD_HI = 2'b01;
    localparam logic [1:0] REG_PRESCALE  = 2'b10;
    localparam logic [1:0] REG_CTRL      = 2'b11;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_ONESHOT = 1;
    localparam int unsigned CTRL_IE      = 2;
    localparam int unsigned CTRL_CLR     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

endpackage

`default_nettype wire

// File: rtl/timer_prescaler.sv
//------------------------------------------------------------------------------
// Module  : timer_prescaler
// Brief   : 8-bit wrap counter (0..limit) emitting a one-cycle tick on wrap.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module timer_prescaler (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_clr,
    input  logic [7:0] i_prescale,
    output logic       o_tick
);

    logic [7:0] r_cnt;
    logic [7:0] r_limit;
    logic       w_wrap;

    assign w_wrap = i_en && (r_cnt == r_limit);
    assign o_tick = w_wrap;

    // The limit is only re-sampled at a wrap (or while parked), so a new
    // prescale value never shortens or stretches the interval in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 8'd0;
            r_limit <= 8'd0;
        end else if (i_clr || !i_en || w_wrap) begin
            r_cnt   <= 8'd0;
            r_limit <= i_prescale;
        end else begin
            r_cnt   <= r_cnt + 8'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/timer_irq_ctrl.sv
//------------------------------------------------------------------------------
// Module  : timer_irq_ctrl
// Brief   : Programmable interval timer generating the CPU timer interrupt.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module timer_irq_ctrl
    import cpu_io_pkg::*;
#(
    parameter int unsigned      WIDTH        = 16,
    parameter logic [1:0]       PORT_ID      = PORT_ID_TIMER,
    parameter logic [WIDTH-1:0] RESET_RELOAD = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_o,
    input  logic [1:0]       io_port,
    input  logic [1:0]       hilo_out,
    input  logic [7:0]       wdata,
    input  logic             irq_ack,
    output logic             i_timer,
    output logic [WIDTH-1:0] count,
    output logic [7:0]       status
);

    timer_state_t     r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic [7:0]       r_lo_shadow;
    logic [7:0]       r_prescale;
    logic             r_oneshot;
    logic             r_ie;
    logic             r_pending;
    logic             r_overrun;

    logic w_wr;
    logic w_wr_ctrl;
    logic w_start;
    logic w_stop;
    logic w_clr;
    logic w_tick;
    logic w_expire;
    logic w_event;

    assign w_wr      = we_o && (io_port == PORT_ID);
    assign w_wr_ctrl = w_wr && (hilo_out == REG_CTRL);
    assign w_start   = w_wr_ctrl && wdata[CTRL_EN] && (r_state != RUN);
    assign w_stop    = w_wr_ctrl && !wdata[CTRL_EN];
    assign w_clr     = w_wr_ctrl && wdata[CTRL_CLR];
    assign w_expire  = (r_state == RUN) && w_tick && (r_count == '0);
    assign w_event   = w_expire && r_ie;

    timer_prescaler u_prescaler (
        .clk        (clk),
        .rst        (reset),
        .i_en       (r_state == RUN),
        .i_clr      (w_start || w_clr),
        .i_prescale (r_prescale),
        .o_tick     (w_tick)
    );

    // Low byte is staged so the 16-bit reload only changes on the high write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lo_shadow <= 8'd0;
            r_reload    <= RESET_RELOAD;
            r_prescale  <= 8'd0;
            r_oneshot   <= 1'b0;
            r_ie        <= 1'b0;
        end else if (w_wr) begin
            case (hilo_out)
                REG_RELOAD_LO: r_lo_shadow <= wdata;
                REG_RELOAD_HI: r_reload    <= WIDTH'({wdata, r_lo_shadow});
                REG_PRESCALE:  r_prescale  <= wdata;
                REG_CTRL: begin
                    r_oneshot <= wdata[CTRL_ONESHOT];
                    r_ie      <= wdata[CTRL_IE];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
        end else if (w_stop) begin
            r_state <= IDLE;
            if (w_clr) begin
                r_count <= r_reload;
            end
        end else if (w_start) begin
            r_state <= RUN;
            r_count <= r_reload;
        end else if (w_clr) begin
            r_count <= r_reload;
        end else if ((r_state == RUN) && w_tick) begin
            if (r_count == '0) begin
                if (r_oneshot) begin
                    r_state <= DONE;
                end else begin
                    r_count <= r_reload;
                end
            end else begin
                r_count <= r_count - WIDTH'(1);
            end
        end
    end

    // An ack landing on the same edge as a new expiry retires the old event
    // only, so the new one stays pending without counting as an overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_event) begin
            r_pending <= 1'b1;
            r_overrun <= irq_ack ? 1'b0 : (r_overrun | r_pending);
        end else if (irq_ack) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign i_timer = r_pending;
    assign count   = r_count;
    assign status  = {5'b0, r_overrun, (r_state == RUN), r_pending};

endmodule

`default_nettype wire

// File: tb/tb_timer_irq_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_timer_irq_ctrl
// Brief   : Self-checking bench for timer_irq_ctrl against a timing model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_timer_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we_o = 1'b0;
    logic [1:0]  io_port = 2'd0;
    logic [1:0]  hilo_out = 2'd0;
    logic [7:0]  wdata = 8'd0;
    logic        irq_ack = 1'b0;
    logic        i_timer;
    logic [15:0] count;
    logic [7:0]  status;

    int total = 0;
    int bad   = 0;

    timer_irq_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .we_o     (we_o),
        .io_port  (io_port),
        .hilo_out (hilo_out),
        .wdata    (wdata),
        .irq_ack  (irq_ack),
        .i_timer  (i_timer),
        .count    (count),
        .status   (status)
    );

    always #5 clk = ~clk;

    // Model: the counter value is derived from cycles elapsed in the current
    // period, expiry from the period length (P+1)*(R+1).
    logic        m_running  = 1'b0;
    logic [15:0] m_frozen   = 16'd0;
    int          m_elapsed  = 0;
    int          m_perP     = 0;
    int          m_perR     = 0;
    logic [15:0] m_reload   = 16'hFFFF;
    logic [7:0]  m_lo       = 8'd0;
    logic [7:0]  m_prescale = 8'd0;
    logic        m_oneshot  = 1'b0;
    logic        m_ie       = 1'b0;
    logic        m_pending  = 1'b0;
    logic        m_overrun  = 1'b0;

    function automatic logic [15:0] exp_count();
        if (m_running)
            return 16'(m_perR - m_elapsed / (m_perP + 1));
        return m_frozen;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin : model
        int          e;
        logic [15:0] old_cnt;
        logic        was_running;
        logic        exp_now;
        if (reset) begin
            m_running = 1'b0; m_frozen = 16'd0; m_elapsed = 0; m_perP = 0; m_perR = 0;
            m_reload = 16'hFFFF; m_lo = 8'd0; m_prescale = 8'd0;
            m_oneshot = 1'b0; m_ie = 1'b0; m_pending = 1'b0; m_overrun = 1'b0;
        end else begin
            old_cnt     = exp_count();
            was_running = m_running;
            exp_now     = 1'b0;
            if (m_running) begin
                e = m_elapsed + 1;
                if (e == (m_perP + 1) * (m_perR + 1)) begin
                    exp_now = 1'b1;
                    if (m_oneshot) begin
                        m_running = 1'b0;
                        m_frozen  = 16'd0;
                    end else begin
                        m_elapsed = 0;
                        m_perR    = int'(m_reload);
                        m_perP    = int'(m_prescale);
                    end
                end else begin
                    m_elapsed = e;
                end
            end
            if (exp_now && m_ie) begin
                if (irq_ack) m_overrun = 1'b0;
                else         m_overrun = m_overrun | m_pending;
                m_pending = 1'b1;
            end else if (irq_ack) begin
                m_pending = 1'b0;
                m_overrun = 1'b0;
            end
            if (we_o && io_port == 2'd3) begin
                case (hilo_out)
                    2'd0: m_lo = wdata;
                    2'd1: m_reload = {wdata, m_lo};
                    2'd2: m_prescale = wdata;
                    default: begin
                        if (wdata[0]) begin
                            if (!was_running) begin
                                m_running = 1'b1;
                                m_elapsed = 0;
                                m_perR    = int'(m_reload);
                                m_perP    = int'(m_prescale);
                            end
                        end else if (m_running) begin
                            m_running = 1'b0;
                            m_frozen  = old_cnt;
                        end
                        m_oneshot = wdata[1];
                        m_ie      = wdata[2];
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_irq", 32'(i_timer), 32'(m_pending));
        chk("cyc_count", 32'(count), 32'(exp_count()));
        chk("cyc_status", 32'(status), 32'({5'b0, m_overrun, m_running, m_pending}));
    end

    // Called at a negedge; the write lands on the following rising edge.
    task automatic wr(input logic [1:0] sel, input logic [7:0] d, input logic [1:0] port);
        we_o = 1'b1; io_port = port; hilo_out = sel; wdata = d;
        @(negedge clk);
        we_o = 1'b0;
    endtask

    task automatic wait_irq(output int n);
        n = 0;
        while (!i_timer && n < 60) begin
            @(negedge clk);
            n = n + 1;
        end
    endtask

    int n;
    int hits;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_irq", 32'(i_timer), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Reload default after reset
        wr(2'd3, 8'h01, 2'd3);
        chk("rst_reload", 32'(count), 32'hFFFF);
        wr(2'd3, 8'h00, 2'd3);

        // Periodic: reload 4, prescale 1 -> period 10
        wr(2'd0, 8'd4, 2'd3);
        wr(2'd1, 8'd0, 2'd3);
        wr(2'd2, 8'd1, 2'd3);
        wr(2'd3, 8'h05, 2'd3);
        wait_irq(n);
        chk("per_first", 32'(n), 32'd10);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        wait_irq(n);
        chk("per_second", 32'(n + 1), 32'd10);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        wr(2'd3, 8'h00, 2'd3);

        // One-shot: reload 2, prescale 0
        wr(2'd0, 8'd2, 2'd3);
        wr(2'd1, 8'd0, 2'd3);
        wr(2'd2, 8'd0, 2'd3);
        wr(2'd3, 8'h07, 2'd3);
        wait_irq(n);
        chk("os_latency", 32'(n), 32'd3);
        chk("os_status", 32'(status), 32'h01);
        chk("os_count", 32'(count), 32'd0);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        hits = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i_timer) hits = hits + 1;
        end
        chk("os_quiet", 32'(hits), 32'd0);

        // Overrun and ack coincident with expiry
        wr(2'd0, 8'd0, 2'd3);
        wr(2'd1, 8'd0, 2'd3);
        wr(2'd3, 8'h05, 2'd3);
        repeat (2) @(negedge clk);
        chk("ovr_status", 32'(status), 32'h07);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("ack_coincident", 32'(status), 32'h03);
        wr(2'd3, 8'h00, 2'd3);
        chk("idle_keeps_pending", 32'(status), 32'h05);
        irq_ack = 1'b1;
        @(negedge clk);
        chk("ack_clear", 32'(status), 32'h00);
        @(negedge clk);
        irq_ack = 1'b0;
        chk("ack_idle_ignored", 32'(status), 32'h00);

        // Atomic reload and port filtering
        wr(2'd0, 8'h10, 2'd3);
        wr(2'd1, 8'h00, 2'd3);
        wr(2'd2, 8'h00, 2'd3);
        wr(2'd0, 8'h34, 2'd3);
        wr(2'd1, 8'h56, 2'd2);
        wr(2'd0, 8'h99, 2'd1);
        io_port = 2'd3; hilo_out = 2'd1; wdata = 8'h77;
        @(negedge clk);
        wr(2'd3, 8'h01, 2'd3);
        chk("atomic_unchanged", 32'(count), 32'h0010);
        wr(2'd1, 8'h12, 2'd3);
        chk("hi_no_disturb", 32'(count), 32'h000F);
        repeat (16) @(negedge clk);
        chk("new_reload", 32'(count), 32'h1234);
        wr(2'd3, 8'h00, 2'd0);
        chk("wrong_port_ctrl", 32'(status), 32'h02);
        wr(2'd3, 8'h00, 2'd3);

        // Expiries without IE, then enabling IE later
        wr(2'd0, 8'd1, 2'd3);
        wr(2'd1, 8'd0, 2'd3);
        wr(2'd3, 8'h01, 2'd3);
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i_timer) hits = hits + 1;
        end
        chk("noie_quiet", 32'(hits), 32'd0);
        wr(2'd3, 8'h05, 2'd3);
        chk("no_stale", 32'(i_timer), 32'd0);
        wait_irq(n);
        chk("ie_later_rises", 32'(n <= 3), 32'd1);

        // Asynchronous reset while running with an interrupt pending
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_irq", 32'(i_timer), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_status", 32'(status), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wr(2'd3, 8'h01, 2'd3);
        chk("arst_reload", 32'(count), 32'hFFFF);
        wr(2'd3, 8'h00, 2'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
